// File: rtl/csi_tx_packetizer.sv
// CSI-2 transmit packetizer for a 4-lane, 8-bit-gear D-PHY PPI.
// Builds the packet header (data ID, word count, ECC), streams 32-bit payload
// words, appends the CRC-16 footer and enforces a minimum idle gap between
// packets. Every lane output is registered.
module csi_tx_packetizer #(
    parameter int MIPI_LANES = 4,
    parameter int MIPI_GEAR  = 8,
    parameter int GAP_CYCLES = 5
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            pkt_valid_i,
    output logic                            pkt_ready_o,
    input  logic [1:0]                      pkt_vc_i,
    input  logic [5:0]                      pkt_dt_i,
    input  logic [15:0]                     pkt_wc_i,
    input  logic                            pld_valid_i,
    output logic                            pld_ready_o,
    input  logic [31:0]                     pld_data_i,
    input  logic                            tx_ready_hs_i,
    output logic [MIPI_LANES-1:0]           tx_valid_hs_o,
    output logic [MIPI_LANES*MIPI_GEAR-1:0] tx_data_hs_o,
    output logic                            err_underflow_o,
    output logic                            err_wc_o
);

    localparam int                    DW        = MIPI_LANES * MIPI_GEAR;
    localparam logic [MIPI_LANES-1:0] ALL_LANES = '1;
    localparam logic [MIPI_LANES-1:0] CRC_LANES = MIPI_LANES'(4'b1100);
    localparam logic [7:0]            GAP_LOAD  = 8'(GAP_CYCLES - 1);

    // The state names what the lanes carry right now.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CRC,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [MIPI_LANES-1:0] valid_q, valid_d;
    logic [DW-1:0]         data_q, data_d;
    logic [15:0]           crc_q, crc_d;
    logic [13:0]           words_q, words_d;
    logic                  long_q, long_d;
    logic [7:0]            gap_q, gap_d;
    logic                  pkt_ready_q, pkt_ready_d;
    logic                  err_uf_q, err_uf_d;
    logic                  err_wc_q, err_wc_d;

    logic                  advance;
    logic                  accept;
    logic                  load_word;
    logic                  load_crc;
    logic                  load_gap;
    logic [31:0]           pld_word;
    logic [23:0]           ecc_in;

    // Header ECC over {wc[15:8], wc[7:0], data_id}.
    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] e;
        e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return e;
    endfunction

    // CRC-16 (x^16+x^12+x^5+1), bytes folded in lane 3,2,1,0 order, LSB-first.
    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [31:0] w);
        logic [15:0] c;
        logic [31:0] sh;
        logic [7:0]  cur;
        logic        fb;
        c  = c_in;
        sh = w;
        for (int k = 0; k < 4; k++) begin
            cur = sh[31:24];
            sh  = sh << 8;
            for (int i = 0; i < 8; i++) begin
                fb    = cur[0] ^ c[0];
                cur   = cur >> 1;
                c     = {c[0], c[15:1]};
                c[15] = fb;
                c[10] = c[10] ^ fb;
                c[3]  = c[3] ^ fb;
            end
        end
        return c;
    endfunction

    assign advance  = (valid_q == '0) || tx_ready_hs_i;
    // Nothing is handshaken on an edge that also resets the block.
    assign pkt_ready_o = pkt_ready_q & reset_n_i;
    assign accept      = pkt_valid_i & pkt_ready_o;
    assign pld_ready_o = load_word & reset_n_i;
    assign ecc_in      = {pkt_wc_i[15:8], pkt_wc_i[7:0], pkt_vc_i, pkt_dt_i};

    // Next-state, next-beat and strobe decode.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        state_d   = state_q;
        valid_d   = valid_q;
        data_d    = data_q;
        crc_d     = crc_q;
        words_d   = words_q;
        long_d    = long_q;
        gap_d     = gap_q;
        err_uf_d  = 1'b0;
        err_wc_d  = 1'b0;
        load_word = 1'b0;
        load_crc  = 1'b0;
        load_gap  = 1'b0;
        pld_word  = pld_valid_i ? pld_data_i : 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_HDR;
                    valid_d  = ALL_LANES;
                    data_d   = {pkt_vc_i, pkt_dt_i, pkt_wc_i[7:0], pkt_wc_i[15:8],
                                2'b00, calc_ecc(ecc_in)};
                    crc_d    = 16'hFFFF;
                    words_d  = pkt_wc_i[15:2];
                    long_d   = (pkt_dt_i >= 6'h10);
                    err_wc_d = (pkt_dt_i >= 6'h10) && (pkt_wc_i[1:0] != 2'b00);
                end
            end
            S_HDR: begin
                if (advance) begin
                    if (!long_q)              load_gap  = 1'b1;
                    else if (words_q != '0)   load_word = 1'b1;
                    else                      load_crc  = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (advance) begin
                    if (words_q != '0) load_word = 1'b1;
                    else               load_crc  = 1'b1;
                end
            end
            S_CRC: begin
                if (advance) load_gap = 1'b1;
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // A missing word still occupies its slot as zeros so the length stays correct.
        if (load_word) begin
            state_d  = S_PAYLOAD;
            valid_d  = ALL_LANES;
            data_d   = pld_word;
            crc_d    = crc_word(crc_q, pld_word);
            words_d  = words_q - 14'd1;
            err_uf_d = !pld_valid_i;
        end
        if (load_crc) begin
            state_d = S_CRC;
            valid_d = CRC_LANES;
            data_d  = {crc_q[7:0], crc_q[15:8], 16'h0000};
        end
        if (load_gap) begin
            state_d = S_GAP;
            valid_d = '0;
            data_d  = '0;
            gap_d   = GAP_LOAD;
        end

        pkt_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset is synchronous and drops the lanes at once.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            data_q      <= '0;
            crc_q       <= 16'hFFFF;
            words_q     <= '0;
            long_q      <= 1'b0;
            gap_q       <= '0;
            pkt_ready_q <= 1'b0;
            err_uf_q    <= 1'b0;
            err_wc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            crc_q       <= crc_d;
            words_q     <= words_d;
            long_q      <= long_d;
            gap_q       <= gap_d;
            pkt_ready_q <= pkt_ready_d;
            err_uf_q    <= err_uf_d;
            err_wc_q    <= err_wc_d;
        end
    end

    assign tx_valid_hs_o   = valid_q;
    assign tx_data_hs_o    = data_q;
    assign err_underflow_o = err_uf_q;
    assign err_wc_o        = err_wc_q;

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Directed bench for csi_tx_packetizer: expected beats go into a scoreboard
// queue when a packet is requested and are compared as beats transfer.
module tb_csi_tx_packetizer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [1:0]  pkt_vc_i;
    logic [5:0]  pkt_dt_i;
    logic [15:0] pkt_wc_i;
    logic        pld_valid_i;
    logic        pld_ready_o;
    logic [31:0] pld_data_i;
    logic        tx_ready_hs_i;
    logic [3:0]  tx_valid_hs_o;
    logic [31:0] tx_data_hs_o;
    logic        err_underflow_o;
    logic        err_wc_o;

    int errors = 0;
    int checks = 0;

    logic [35:0] exp_q[$];
    logic [31:0] pay_q[$];
    logic [31:0] vec [6];
    int          slot      = 0;
    int          hole_slot = -1;
    int          uf_cnt    = 0;
    int          wc_cnt    = 0;

    csi_tx_packetizer #(.MIPI_LANES(4), .MIPI_GEAR(8), .GAP_CYCLES(5)) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .pkt_valid_i    (pkt_valid_i),
        .pkt_ready_o    (pkt_ready_o),
        .pkt_vc_i       (pkt_vc_i),
        .pkt_dt_i       (pkt_dt_i),
        .pkt_wc_i       (pkt_wc_i),
        .pld_valid_i    (pld_valid_i),
        .pld_ready_o    (pld_ready_o),
        .pld_data_i     (pld_data_i),
        .tx_ready_hs_i  (tx_ready_hs_i),
        .tx_valid_hs_o  (tx_valid_hs_o),
        .tx_data_hs_o   (tx_data_hs_o),
        .err_underflow_o(err_underflow_o),
        .err_wc_o       (err_wc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic par(input logic [23:0] d, input logic [23:0] mask);
        return ^(d & mask);
    endfunction

    // Header beat with ECC from per-bit parity masks.
    function automatic logic [35:0] hdr_beat(input logic [1:0] vc, input logic [5:0] dt,
                                              input logic [15:0] wc);
        logic [23:0] d;
        logic [5:0]  e;
        d = {wc[15:8], wc[7:0], vc, dt};
        e = {par(d, 24'hEFFC00), par(d, 24'hDF03F0), par(d, 24'hB8E38E),
             par(d, 24'h749A6D), par(d, 24'hF2555B), par(d, 24'hF12CB7)};
        return {4'hF, vc, dt, wc[7:0], wc[15:8], 2'b00, e};
    endfunction

    // Reflected CRC-CCITT, one byte LSB-first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic [7:0]  v;
        r = c;
        v = b;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ v[0]) == 1'b1) r = (r >> 1) ^ 16'h8408;
            else                       r = r >> 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Queue the expected beats of a long packet and the payload to feed it.
    task automatic push_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int hole, input logic with_crc,
                             input logic fixed, input logic [15:0] fixed_crc);
        logic [15:0] c;
        logic [31:0] w;
        int          n;
        n = int'(wc >> 2);
        c = 16'hFFFF;
        exp_q.push_back(hdr_beat(vc, dt, wc));
        for (int i = 0; i < n; i++) begin
            w = (i == hole) ? 32'h0 : vec[i];
            if (i != hole) pay_q.push_back(vec[i]);
            exp_q.push_back({4'hF, w});
            c = crc_byte(c, w[31:24]);
            c = crc_byte(c, w[23:16]);
            c = crc_byte(c, w[15:8]);
            c = crc_byte(c, w[7:0]);
        end
        if (fixed) c = fixed_crc;
        if (with_crc) exp_q.push_back({4'b1100, c[7:0], c[15:8], 16'h0000});
    endtask

    // Present a request and hold it until accepted; returns in the header cycle.
    task automatic request(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        int n;
        pkt_vc_i    = vc;
        pkt_dt_i    = dt;
        pkt_wc_i    = wc;
        pkt_valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (pkt_ready_o !== 1'b1 && n < 50);
        check("req_accept", 36'(pkt_ready_o), 36'h1);
        @(posedge clk_i);
        #1;
        pkt_valid_i = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard drains and a new request may be taken.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_ready_o !== 1'b1) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_drained"}, 36'(exp_q.size()), 36'h0);
        check({tag, "_ready"}, 36'(pkt_ready_o), 36'h1);
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every transferring beat is compared against the queue head.
    always @(negedge clk_i) begin
        if (reset_n_i && tx_valid_hs_o != 4'h0 && tx_ready_hs_i) begin
            if (exp_q.size() == 0) check("beat_unexpected", {tx_valid_hs_o, tx_data_hs_o}, 36'h0);
            else                   check("beat", {tx_valid_hs_o, tx_data_hs_o}, exp_q.pop_front());
        end
    end

    // Error pulse counters.
    always @(negedge clk_i) begin
        if (err_underflow_o) uf_cnt++;
        if (err_wc_o)        wc_cnt++;
    end

    // Payload source: offers the queue head, optionally withholding one slot.
    initial begin : pld_driver
        logic took;
        pld_valid_i = 1'b0;
        pld_data_i  = 32'h0;
        forever begin
            @(negedge clk_i);
            took = pld_ready_o;
            @(posedge clk_i);
            #1;
            if (took) begin
                if (pld_valid_i) void'(pay_q.pop_front());
                slot++;
            end
            if (slot != hole_slot && pay_q.size() != 0) begin
                pld_valid_i = 1'b1;
                pld_data_i  = pay_q[0];
            end else begin
                pld_valid_i = 1'b0;
                pld_data_i  = 32'h0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int base_uf;
        int base_wc;
        vec[0] = 32'hFF000002; vec[1] = 32'hB9DCF372; vec[2] = 32'hBBD4B85A;
        vec[3] = 32'hC875C27C; vec[4] = 32'h81F805DF; vec[5] = 32'hFF000001;
        reset_n_i = 1'b0; pkt_valid_i = 1'b0; pkt_vc_i = '0; pkt_dt_i = '0;
        pkt_wc_i = '0; tx_ready_hs_i = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_valid", 36'(tx_valid_hs_o), 36'h0);
        check("rst_data", 36'(tx_data_hs_o), 36'h0);
        check("rst_pkt_ready", 36'(pkt_ready_o), 36'h0);
        check("rst_pld_ready", 36'(pld_ready_o), 36'h0);
        check("rst_err", 36'({err_underflow_o, err_wc_o}), 36'h0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("ready_after_release", 36'(pkt_ready_o), 36'h1);
        @(posedge clk_i); #1;

        // FS short packet: one beat, five idle cycles, ready on cycle 7.
        exp_q.push_back({4'hF, 32'h40000016});
        request(2'd1, 6'h00, 16'h0000);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_i);
            check($sformatf("fs_valid_c%0d", c), 36'(tx_valid_hs_o), (c == 1) ? 36'hF : 36'h0);
            check($sformatf("fs_ready_c%0d", c), 36'(pkt_ready_o), (c == 7) ? 36'h1 : 36'h0);
            if (c == 2) check("fs_gap_data", 36'(tx_data_hs_o), 36'h0);
            @(posedge clk_i); #1;
        end
        check("fs_drained", 36'(exp_q.size()), 36'h0);

        // Empty long packet: header then CRC of nothing.
        exp_q.push_back({4'hF, 32'h2A000010});
        exp_q.push_back({4'b1100, 32'hFFFF0000});
        request(2'd0, 6'h2A, 16'h0000);
        wait_idle("long_wc0");

        // Reference 24-byte packet, CRC 0x00F0.
        base_uf = uf_cnt;
        base_wc = wc_cnt;
        push_long(2'd0, 6'h2A, 16'd24, -1, 1'b1, 1'b1, 16'h00F0);
        request(2'd0, 6'h2A, 16'd24);
        wait_idle("long_ref");
        check("ref_no_underflow", 36'(uf_cnt - base_uf), 36'h0);
        check("ref_no_wc_err", 36'(wc_cnt - base_wc), 36'h0);

        // Same packet with a 3-cycle lane stall on the second payload word.
        push_long(2'd0, 6'h2A, 16'd24, -1, 1'b1, 1'b1, 16'h00F0);
        request(2'd0, 6'h2A, 16'd24);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        tx_ready_hs_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            check("stall_hold", {tx_valid_hs_o, tx_data_hs_o}, {4'hF, vec[1]});
            check("stall_pld_ready", 36'(pld_ready_o), 36'h0);
            @(posedge clk_i); #1;
        end
        tx_ready_hs_i = 1'b1;
        wait_idle("long_stall");

        // Third payload word withheld: zeros sent, one underflow pulse.
        base_uf   = uf_cnt;
        hole_slot = slot + 2;
        push_long(2'd0, 6'h2A, 16'd24, 2, 1'b1, 1'b0, 16'h0000);
        request(2'd0, 6'h2A, 16'd24);
        wait_idle("long_underflow");
        check("underflow_pulses", 36'(uf_cnt - base_uf), 36'h1);
        hole_slot = -1;

        // wc=6: one word, err_wc pulse, then reset in the middle of the payload.
        base_wc = wc_cnt;
        push_long(2'd0, 6'h2A, 16'd6, -1, 1'b0, 1'b0, 16'h0000);
        request(2'd0, 6'h2A, 16'd6);
        @(negedge clk_i);
        check("wc6_err_wc", 36'(err_wc_o), 36'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("wc6_payload", {tx_valid_hs_o, tx_data_hs_o}, {4'hF, vec[0]});
        check("wc6_err_wc_clear", 36'(err_wc_o), 36'h0);
        #1;
        reset_n_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("midrst_valid", 36'(tx_valid_hs_o), 36'h0);
        check("midrst_data", 36'(tx_data_hs_o), 36'h0);
        check("midrst_pkt_ready", 36'(pkt_ready_o), 36'h0);
        check("midrst_pld_ready", 36'(pld_ready_o), 36'h0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        check("midrst_sb_empty", 36'(exp_q.size()), 36'h0);
        check("wc6_pulses", 36'(wc_cnt - base_wc), 36'h1);
        pay_q.delete();
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("midrst_idle", 36'(pkt_ready_o), 36'h1);
        for (int s = 0; s < 6; s++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            check("midrst_no_crc", 36'(tx_valid_hs_o), 36'h0);
        end
        @(posedge clk_i); #1;

        // Short packet with a nontrivial data field after recovery.
        exp_q.push_back(hdr_beat(2'd2, 6'h01, 16'h1234));
        request(2'd2, 6'h01, 16'h1234);
        wait_idle("short_after_reset");

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
